// File: rtl/croc_pkg.sv
// ============================================================================
// Module   : croc_pkg
// Brief    : Shared boot-sequencer state type and default timing constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package croc_pkg;

    typedef enum logic [1:0] {
        BootHold      = 2'd0,
        BootWaitFetch = 2'd1,
        BootDelay     = 2'd2,
        BootRun       = 2'd3
    } boot_state_e;

    localparam int BootResetHoldCycles  = 16;
    localparam int BootFetchDelayCycles = 8;
    localparam int BootWdtCycles        = 2 ** 20;

endpackage

`default_nettype wire

// File: rtl/croc_boot_wdt.sv
// ============================================================================
// Module   : croc_boot_wdt
// Brief    : Busy-activity watchdog; trips when core_busy_i is static in RUN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module croc_boot_wdt
    import croc_pkg::*;
#(
    parameter int WdtCycles = BootWdtCycles,
    parameter int CntWidth  = 21
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic core_busy_i,
    input  logic in_run,
    output logic trip,
    output logic fired
);

    localparam logic [CntWidth-1:0] WDT_LAST = CntWidth'(WdtCycles - 1);
    localparam logic [CntWidth-1:0] ONE      = CntWidth'(1);

    logic                busy_q;
    logic                busy_edge;
    logic [CntWidth-1:0] cnt;

    assign busy_edge = (core_busy_i != busy_q);
    assign trip      = in_run && !busy_edge && (cnt == WDT_LAST);

    // Held at zero outside RUN, so entering RUN always starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            fired  <= 1'b0;
        end else begin
            busy_q <= core_busy_i;
            if (!in_run || busy_edge || trip) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + ONE;
            end
            if (trip) begin
                fired <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/croc_boot_ctrl.sv
// ============================================================================
// Module   : croc_boot_ctrl
// Brief    : Boot/reset sequencer for croc_domain (hold, fetch settle, run).
//            Optional busy watchdog enabled by macro CROC_BOOT_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module croc_boot_ctrl
    import croc_pkg::*;
#(
    parameter int ResetHoldCycles  = BootResetHoldCycles,
    parameter int FetchDelayCycles = BootFetchDelayCycles,
    parameter int WdtCycles        = BootWdtCycles,
    parameter int CntWidth         = 21
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       fetch_en_i,
    input  logic       soft_rst_req_i,
    input  logic       core_busy_i,
    output logic       dom_rst_no,
    output logic       fetch_en_o,
    output logic       boot_done_o,
    output logic [1:0] state_o,
    output logic       wdt_fired_o
);

    localparam logic [CntWidth-1:0] HOLD_LAST  = CntWidth'(ResetHoldCycles - 1);
    localparam logic [CntWidth-1:0] DELAY_LAST = CntWidth'(FetchDelayCycles - 1);
    localparam logic [CntWidth-1:0] ONE        = CntWidth'(1);

    boot_state_e         state;
    boot_state_e         next_state;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] next_cnt;
    logic                wdt_trip;

`ifdef CROC_BOOT_WATCHDOG_EN
    croc_boot_wdt #(
        .WdtCycles (WdtCycles),
        .CntWidth  (CntWidth)
    ) u_wdt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .core_busy_i (core_busy_i),
        .in_run      (state == BootRun),
        .trip        (wdt_trip),
        .fired       (wdt_fired_o)
    );
`else
    logic unused_core_busy;
    localparam int unused_wdt_cycles = WdtCycles;

    assign unused_core_busy = core_busy_i;
    assign wdt_trip         = 1'b0;
    assign wdt_fired_o      = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_cnt   = (cnt == '1) ? cnt : cnt + ONE;
        case (state)
            BootHold: begin
                if (cnt == HOLD_LAST) begin
                    next_state = BootWaitFetch;
                    next_cnt   = '0;
                end
            end
            BootWaitFetch: begin
                next_cnt = '0;
                if (fetch_en_i) begin
                    if (FetchDelayCycles == 0) begin
                        next_state = BootRun;
                    end else begin
                        next_state = BootDelay;
                    end
                end
            end
            BootDelay: begin
                if (!fetch_en_i) begin
                    next_state = BootWaitFetch;
                    next_cnt   = '0;
                end else if (cnt == DELAY_LAST) begin
                    next_state = BootRun;
                    next_cnt   = '0;
                end
            end
            BootRun: begin
                next_cnt = '0;
            end
            default: begin
                next_state = BootHold;
                next_cnt   = '0;
            end
        endcase
        // Soft reset and watchdog override every other transition.
        if (soft_rst_req_i || wdt_trip) begin
            next_state = BootHold;
            next_cnt   = '0;
        end
    end

    // Outputs decode next_state so they move on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= BootHold;
            cnt         <= '0;
            dom_rst_no  <= 1'b0;
            fetch_en_o  <= 1'b0;
            boot_done_o <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            dom_rst_no  <= (next_state != BootHold);
            fetch_en_o  <= (next_state == BootRun);
            boot_done_o <= (next_state == BootRun);
        end
    end

    assign state_o = state;

endmodule

`default_nettype wire
